// File: rtl/rggen_host_if_apb_ext.sv
// rtl/rggen_host_if_apb_ext.sv - APB host interface with command capture, PPROT filtering and response timeout
//
// Purpose:
//   Converts APB transfers into the local register-block command bus. The
//   setup phase is captured into registers, PPROT is screened before any
//   local command is issued, and an optional cycle budget terminates a hung
//   local command with PSLVERR.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_p*                APB requester side (paddr/pprot/psel/penable/pwrite/pwdata/pstrb)
//   o_pready/o_prdata/o_pslverr  APB completer response
//   o_command_valid/o_write/o_read/o_address/o_write_data/o_write_mask  local command
//   i_response_ready/i_read_data/i_status  local response
//   o_timeout           one-cycle pulse, aligned with o_pready, when a command timed out
module rggen_host_if_apb_ext #(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 0,
  parameter int REQUIRE_PRIVILEGED  = 0,
  parameter int REQUIRE_SECURE      = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
  output logic                           o_pready,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pslverr,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status,
  output logic                           o_timeout
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int COUNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_LAST);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPONSE,
    ERROR
  } state_e;

  state_e                         state_q, state_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                           write_q, write_d;
  logic [DATA_WIDTH-1:0]          write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]          write_mask_q, write_mask_d;
  logic [DATA_WIDTH-1:0]          prdata_q, prdata_d;
  logic                           pslverr_q, pslverr_d;
  logic                           timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0]         count_q, count_d;

  logic [DATA_WIDTH-1:0]          strb_mask;
  logic                           setup_phase;
  logic                           protection_fail;
  logic                           timeout_hit;

  // Upper address bits, pprot[2] and status[0] carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{i_paddr, i_pprot[2], i_status[0]};

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strb_mask[8*i +: 8] = {8{i_pstrb[i]}};
    end
  end

  assign setup_phase     = i_psel && !i_penable;
  assign protection_fail = ((REQUIRE_PRIVILEGED != 0) && !i_pprot[0]) ||
                           ((REQUIRE_SECURE != 0) && i_pprot[1]);
  assign timeout_hit     = (TIMEOUT_CYCLES > 0) && (count_q == COUNT_LAST);

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    write_d      = write_q;
    write_data_d = write_data_q;
    write_mask_d = write_mask_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    timeout_d    = 1'b0;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (setup_phase) begin
          address_d    = i_paddr[LOCAL_ADDRESS_WIDTH-1:0];
          write_d      = i_pwrite;
          write_data_d = i_pwdata;
          write_mask_d = i_pwrite ? strb_mask : '0;
          count_d      = '0;
          prdata_d     = '0;
          // A rejected transfer answers straight from ERROR with an error.
          pslverr_d    = protection_fail;
          state_d      = protection_fail ? ERROR : BUSY;
        end
      end
      BUSY: begin
        if (i_response_ready) begin
          // The local response takes priority over an expiring budget.
          prdata_d  = write_q ? '0 : i_read_data;
          pslverr_d = i_status[1];
          state_d   = RESPONSE;
        end else if (timeout_hit) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESPONSE;
        end else begin
          count_d = count_q + COUNT_ONE;
        end
      end
      RESPONSE: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      write_mask_q <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_q      <= write_d;
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign o_command_valid = (state_q == BUSY);
  assign o_write         = o_command_valid && write_q;
  assign o_read          = o_command_valid && !write_q;
  assign o_address       = address_q;
  assign o_write_data    = write_data_q;
  assign o_write_mask    = write_mask_q;

  assign o_pready  = (state_q == RESPONSE) || (state_q == ERROR);
  assign o_prdata  = o_pready ? prdata_q : '0;
  assign o_pslverr = o_pready && pslverr_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rggen_host_if_apb_ext.sv
// tb/tb_rggen_host_if_apb_ext.sv - self-checking bench for rggen_host_if_apb_ext
module tb_rggen_host_if_apb_ext;

  localparam int DW  = 32;
  localparam int HAW = 16;
  localparam int LAW = 8;
  localparam int TO  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [HAW-1:0]  i_paddr;
  logic [2:0]      i_pprot;
  logic            i_psel;
  logic            i_penable;
  logic            i_pwrite;
  logic [DW-1:0]   i_pwdata;
  logic [DW/8-1:0] i_pstrb;
  logic            o_pready;
  logic [DW-1:0]   o_prdata;
  logic            o_pslverr;
  logic            o_command_valid;
  logic            o_write;
  logic            o_read;
  logic [LAW-1:0]  o_address;
  logic [DW-1:0]   o_write_data;
  logic [DW-1:0]   o_write_mask;
  logic            i_response_ready;
  logic [DW-1:0]   i_read_data;
  logic [1:0]      i_status;
  logic            o_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rggen_host_if_apb_ext #(
    .DATA_WIDTH          (DW),
    .HOST_ADDRESS_WIDTH  (HAW),
    .LOCAL_ADDRESS_WIDTH (LAW),
    .TIMEOUT_CYCLES      (TO),
    .REQUIRE_PRIVILEGED  (1),
    .REQUIRE_SECURE      (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_paddr          (i_paddr),
    .i_pprot          (i_pprot),
    .i_psel           (i_psel),
    .i_penable        (i_penable),
    .i_pwrite         (i_pwrite),
    .i_pwdata         (i_pwdata),
    .i_pstrb          (i_pstrb),
    .o_pready         (o_pready),
    .o_prdata         (o_prdata),
    .o_pslverr        (o_pslverr),
    .o_command_valid  (o_command_valid),
    .o_write          (o_write),
    .o_read           (o_read),
    .o_address        (o_address),
    .o_write_data     (o_write_data),
    .o_write_mask     (o_write_mask),
    .i_response_ready (i_response_ready),
    .i_read_data      (i_read_data),
    .i_status         (i_status),
    .o_timeout        (o_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd"},   {o_command_valid, o_write, o_read}, 0);
    check({tag, "_addr"},  o_address, 0);
    check({tag, "_wdata"}, o_write_data, 0);
    check({tag, "_mask"},  o_write_mask, 0);
    check({tag, "_resp"},  {o_pready, o_pslverr, o_timeout}, 0);
    check({tag, "_rdata"}, o_prdata, 0);
  endtask

  // k = BUSY cycle (1-based) in which the local response arrives; 0 = never.
  task automatic xfer(input string tag, input bit wr, input logic [HAW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                      input logic [2:0] prot, input int k, input logic [1:0] status,
                      input logic [DW-1:0] rdata);
    bit            prot_ok;
    int            exp_busy;
    int            exp_ready_cyc;
    bit            exp_to;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_mask;
    int            cv;
    int            to_cnt;
    bit            got;

    // Reference: privileged (pprot[0]) and non-secure-rejecting (pprot[1]) rules,
    // at most TO BUSY cycles before the budget expires.
    prot_ok  = prot[0] && !prot[1];
    exp_mask = '0;
    if (wr) for (int i = 0; i < DW/8; i++) if (strb[i]) exp_mask = exp_mask | (32'hFF << (8*i));
    if (!prot_ok) begin
      exp_busy = 0; exp_ready_cyc = 1; exp_to = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (k >= 1 && k <= TO) begin
      exp_busy = k; exp_ready_cyc = k + 1; exp_to = 0; exp_err = status[1];
      exp_rd = wr ? '0 : rdata;
    end else begin
      exp_busy = TO; exp_ready_cyc = TO + 1; exp_to = 1; exp_err = 1'b1; exp_rd = '0;
    end

    i_paddr = addr; i_pprot = prot; i_pwrite = wr; i_pwdata = wdata; i_pstrb = strb;
    i_psel = 1'b1; i_penable = 1'b0;
    @(posedge clk); #1;
    i_penable = 1'b1;
    cv = 0; to_cnt = 0; got = 0;
    for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
      i_response_ready = (cyc == k);
      i_read_data      = rdata;
      i_status         = status;
      @(negedge clk);
      if (o_timeout) to_cnt++;
      if (o_command_valid) begin
        cv++;
        check({tag, "_addr"}, o_address, addr[LAW-1:0]);
        check({tag, "_rw"},   {o_write, o_read}, {wr, !wr});
        check({tag, "_mask"}, o_write_mask, exp_mask);
        if (wr) check({tag, "_wdata"}, o_write_data, wdata);
      end else begin
        check({tag, "_rw_idle"}, {o_write, o_read}, 2'b00);
      end
      if (o_pready) begin
        got = 1;
        check({tag, "_ready_cyc"}, cyc, exp_ready_cyc);
        check({tag, "_prdata"},    o_prdata, exp_rd);
        check({tag, "_pslverr"},   o_pslverr, exp_err);
        check({tag, "_timeout"},   o_timeout, exp_to);
      end else begin
        check({tag, "_idle_resp"}, {o_pslverr, o_prdata}, 0);
      end
      @(posedge clk); #1;
    end
    if (!got) check({tag, "_pready_seen"}, 0, 1);
    i_response_ready = 1'b0;
    i_psel = 1'b0; i_penable = 1'b0;
    check({tag, "_busy_cycles"}, cv, exp_busy);
    check({tag, "_timeout_pulses"}, to_cnt, exp_to);
  endtask

  initial begin
    rst_n = 1'b0;
    i_paddr = '0; i_pprot = '0; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_pwdata = '0; i_pstrb = '0; i_response_ready = 1'b0; i_read_data = '0; i_status = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer("wr_first", 1'b1, 16'h0004, 32'hA5A5_0F0F, 4'b0011, 3'b001, 1, 2'b00, 32'h0);
    xfer("rd_delay3", 1'b0, 16'h0008, 32'h0, 4'b0000, 3'b001, 3, 2'b00, 32'hDEAD_BEEF);
    xfer("priv_fail", 1'b1, 16'h0010, 32'h1234_5678, 4'b1111, 3'b000, 1, 2'b00, 32'h0);
    xfer("sec_fail", 1'b0, 16'h0014, 32'h0, 4'b0000, 3'b011, 1, 2'b00, 32'hCAFE_F00D);
    xfer("timeout", 1'b0, 16'h0020, 32'h0, 4'b0000, 3'b001, 0, 2'b00, 32'h1234_5678);
    xfer("resp_at_limit", 1'b0, 16'h0024, 32'h0, 4'b0000, 3'b001, 4, 2'b10, 32'h0BAD_0BAD);
    xfer("resp_at_limit_ok", 1'b1, 16'h0028, 32'h5555_AAAA, 4'b1000, 3'b101, 4, 2'b00, 32'h0);
    xfer("status_err", 1'b0, 16'h0030, 32'h0, 4'b0000, 3'b001, 2, 2'b10, 32'h8765_4321);
    xfer("b2b_after_err", 1'b1, 16'h0034, 32'h0F0F_F0F0, 4'b0110, 3'b001, 1, 2'b00, 32'h0);

    // Asynchronous reset in the middle of a BUSY command.
    i_paddr = 16'h12F3; i_pprot = 3'b001; i_pwrite = 1'b1; i_pwdata = 32'hFFFF_0001;
    i_pstrb = 4'b1111; i_psel = 1'b1; i_penable = 1'b0;
    @(posedge clk); #1;
    i_penable = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_busy", o_command_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    i_psel = 1'b0; i_penable = 1'b0;
    @(posedge clk); #1;
    check_all_zero("held_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer("after_reset", 1'b0, 16'h0040, 32'h0, 4'b0000, 3'b001, 2, 2'b00, 32'h3C3C_A5A5);

    for (int n = 0; n < 16; n++) begin
      bit            wr;
      logic [2:0]    prot;
      int            k;
      logic [DW-1:0] rnd_w;
      logic [DW-1:0] rnd_r;
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       prot = 3'b000;
        1:       prot = 3'b011;
        2:       prot = 3'b101;
        default: prot = 3'b001;
      endcase
      k     = $urandom_range(0, 5);
      rnd_w = $urandom;
      rnd_r = $urandom;
      xfer("rand", wr, 16'($urandom), rnd_w, 4'($urandom), prot, k,
           2'($urandom_range(0, 3)), rnd_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
